// File: rtl/result_drain.sv
// Snapshot reader for the systolic multiplier's parallel NxN result: captures on valid,
// pulses the multiplier clear, then streams the snapshot out one row per valid/ready transfer.
module result_drain #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned N            = 4,
  parameter int unsigned C_DATA_WIDTH = 2 * DATA_WIDTH + $clog2(N),
  localparam int unsigned IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset_i,
  input  logic                                     mm_valid_i,
  input  logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0]    mm_c_i,
  output logic                                     mm_clear_o,
  output logic                                     busy_o,
  output logic                                     row_valid_o,
  input  logic                                     row_ready_i,
  output logic [N-1:0][C_DATA_WIDTH-1:0]           row_data_o,
  output logic [IDX_W-1:0]                         row_idx_o,
  output logic                                     row_last_o
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      row_idx_q, row_idx_d;
  logic [N-1:0][N-1:0][C_DATA_WIDTH-1:0] buf_q, buf_d;
  logic                                  clear_q, clear_d;
  logic                                  xfer;
  logic                                  at_last;
  logic                                  take;

  assign xfer    = (state_q == StStream) && row_ready_i;
  assign at_last = (row_idx_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    buf_d     = buf_q;
    clear_d   = 1'b0;
    take      = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The multiplier still shows its old valid during the clear cycle.
        take = mm_valid_i && !clear_q;
      end
      StStream: begin
        if (xfer) begin
          if (at_last) begin
            row_idx_d = '0;
            take      = mm_valid_i && !clear_q;
            if (!take) begin
              state_d = StIdle;
            end
          end else begin
            row_idx_d = row_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (take) begin
      buf_d     = mm_c_i;
      row_idx_d = '0;
      state_d   = StStream;
      clear_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      row_idx_q <= '0;
      buf_q     <= '0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      buf_q     <= buf_d;
      clear_q   <= clear_d;
    end
  end

  always_comb begin
    row_valid_o = (state_q == StStream);
    busy_o      = (state_q == StStream);
    row_data_o  = row_valid_o ? buf_q[row_idx_q] : '0;
    row_idx_o   = row_idx_q;
    row_last_o  = row_valid_o && at_last;
    mm_clear_o  = clear_q;
  end

endmodule
